// File: rtl/shift_engine_seq_pkg.sv
// Shared definitions for the sequential shift engine: shift op codes and op helpers.
package shift_engine_seq_pkg;

  typedef logic [2:0] shop_t;

  localparam shop_t SHOP_SRL = 3'b000;
  localparam shop_t SHOP_SLL = 3'b001;
  localparam shop_t SHOP_SRA = 3'b010;
  localparam shop_t SHOP_ROR = 3'b011;
  localparam shop_t SHOP_ROL = 3'b100;

  // Codes above ROL are reserved: the operand passes through and ERR is flagged.
  function automatic logic shop_is_reserved(input shop_t op);
    return (op > SHOP_ROL);
  endfunction

endpackage

// File: rtl/shift_engine_seq_if.sv
// Request/response bundle between the ALU controller and the shift engine.
interface shift_engine_seq_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);
  import shift_engine_seq_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Request side: in_valid/D/S/OP from controller, in_ready from engine.
  // Result side: out_valid/Y/ZERO/ERR from engine, out_ready from controller;
  // the engine holds Y/ZERO/ERR stable while out_valid=1 and out_ready=0.
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  D;
  logic [SHAMT_WIDTH-1:0] S;
  shop_t                  OP;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  Y;
  logic                   ZERO;
  logic                   ERR;

  modport master (
    output in_valid, D, S, OP, out_ready,
    input  in_ready, out_valid, Y, ZERO, ERR
  );

  modport slave (
    input  in_valid, D, S, OP, out_ready,
    output in_ready, out_valid, Y, ZERO, ERR
  );

endinterface

// File: rtl/shift_engine_seq_shift_stage.sv
// One barrel stage: shifts or rotates the value by 2^k according to op, or passes it through.
module shift_stage
  import shift_engine_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0]  value,
  input  logic [SHAMT_WIDTH-1:0] k,
  input  logic                   enable,
  input  shop_t                  op,
  input  logic                   sign,
  output logic [DATA_WIDTH-1:0]  result
);

  localparam int AW = SHAMT_WIDTH + 1;
  localparam logic [AW-1:0] WIDTH_L = AW'(DATA_WIDTH);

  logic [AW-1:0]         amt;
  logic [AW-1:0]         amt_c;
  logic [DATA_WIDTH-1:0] fill;

  always_comb begin
    amt   = AW'(1) << k;
    amt_c = WIDTH_L - amt;
    // Sign bits that SRA moves into the vacated top positions.
    fill  = ~({DATA_WIDTH{1'b1}} >> amt) & {DATA_WIDTH{sign}};
    result = value;
    if (enable) begin
      case (op)
        SHOP_SRL: result = value >> amt;
        SHOP_SLL: result = value << amt;
        SHOP_SRA: result = (value >> amt) | fill;
        SHOP_ROR: result = (value >> amt) | (value << amt_c);
        SHOP_ROL: result = (value << amt) | (value >> amt_c);
        default:  result = value;
      endcase
    end
  end

endmodule

// File: rtl/shift_engine_seq.sv
// Multi-cycle shift/rotate engine resolving one shift-amount bit per clock,
// with valid/ready handshakes on request and result.
module shift_engine_seq
  import shift_engine_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter bit EARLY_DONE  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  shift_engine_seq_if.slave     bus,
  output logic [1:0]            dbg_state   // 0 = IDLE, 1 = SHIFT, 2 = DONE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_WIDTH-1:0] LAST_K = SHAMT_WIDTH'(SHAMT_WIDTH - 1);

  state_t                 state, state_nx;
  logic [DATA_WIDTH-1:0]  work;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [SHAMT_WIDTH-1:0] k;
  shop_t                  op_r;
  logic                   sign_r;
  logic [DATA_WIDTH-1:0]  y_r;
  logic                   zero_r;
  logic                   err_r;
  logic [DATA_WIDTH-1:0]  stage_out;
  logic                   accept;
  logic                   last_stage;
  logic                   upper_zero;

  shift_stage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_stage (
    .value  (work),
    .k      (k),
    .enable (shamt[k]),
    .op     (op_r),
    .sign   (sign_r),
    .result (stage_out)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    // Stages above k that are all zero cannot change the value any more.
    upper_zero = ((shamt >> k) >> 1) == '0;
    last_stage = (k == LAST_K) || (EARLY_DONE && upper_zero);
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_stage) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      work   <= '0;
      shamt  <= '0;
      k      <= '0;
      op_r   <= SHOP_SRL;
      sign_r <= 1'b0;
      y_r    <= '0;
      zero_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (accept) begin
      work   <= bus.D;
      shamt  <= bus.S;
      op_r   <= bus.OP;
      sign_r <= bus.D[DATA_WIDTH-1];
      k      <= '0;
    end else if (state == ST_SHIFT) begin
      work <= stage_out;
      k    <= k + 1'b1;
      if (last_stage) begin
        y_r    <= stage_out;
        zero_r <= (stage_out == '0);
        err_r  <= shop_is_reserved(op_r);
      end
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.Y         = y_r;
  assign bus.ZERO      = zero_r;
  assign bus.ERR       = err_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_shift_engine_seq.sv
// Bench for shift_engine_seq: fixed-latency and early-done instances, scoreboard on results.
module tb_shift_engine_seq;
  import shift_engine_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] st0, st1;
  int         checks = 0;
  int         errors = 0;
  logic [33:0] exp0_q[$];
  logic [33:0] exp1_q[$];
  logic [33:0] got0, got1, e0, e1;

  shift_engine_seq_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus0();
  shift_engine_seq_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus1();

  shift_engine_seq #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .EARLY_DONE(1'b0)) dut0 (
    .CLK(clk), .RST(rst), .bus(bus0), .dbg_state(st0));
  shift_engine_seq #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .EARLY_DONE(1'b1)) dut1 (
    .CLK(clk), .RST(rst), .bus(bus1), .dbg_state(st1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: one pop per completed result transfer
  always @(negedge clk) begin
    if (bus0.out_valid && bus0.out_ready) begin
      checks++;
      got0 = {bus0.ERR, bus0.ZERO, bus0.Y};
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected: got err/zero/y=%h, required no output", got0);
      end else begin
        e0 = exp0_q.pop_front();
        if (got0 !== e0) begin
          errors++;
          $display("FAIL sb0_result: got err/zero/y=%h, required %h", got0, e0);
        end
      end
    end
    if (bus1.out_valid && bus1.out_ready) begin
      checks++;
      got1 = {bus1.ERR, bus1.ZERO, bus1.Y};
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected: got err/zero/y=%h, required no output", got1);
      end else begin
        e1 = exp1_q.pop_front();
        if (got1 !== e1) begin
          errors++;
          $display("FAIL sb1_result: got err/zero/y=%h, required %h", got1, e1);
        end
      end
    end
  end

  // reference model, written directly from the operation definitions
  function automatic logic [31:0] ref_y(input logic [31:0] d, input logic [4:0] s, input logic [2:0] op);
    case (op)
      3'b000:  return d >> s;
      3'b001:  return d << s;
      3'b010:  return 32'($signed(d) >>> s);
      3'b011:  return (s == 0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
      3'b100:  return (s == 0) ? d : ((d << s) | (d >> (6'd32 - {1'b0, s})));
      default: return d;
    endcase
  endfunction

  function automatic logic [33:0] pack_exp(input logic [31:0] y, input logic err);
    return {err, (y == 32'd0), y};
  endfunction

  // driver tasks
  task automatic drive_req(input bit which, input logic [31:0] d, input logic [4:0] s,
                           input logic [2:0] op, input logic [33:0] exp, input bit push);
    int guard = 0;
    while (!(which ? bus1.in_ready : bus0.in_ready) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: dut%0d not idle after %0d cycles, required idle", which, guard);
    end
    if (which) begin
      bus1.in_valid = 1'b1; bus1.D = d; bus1.S = s; bus1.OP = op;
      if (push) exp1_q.push_back(exp);
    end else begin
      bus0.in_valid = 1'b1; bus0.D = d; bus0.S = s; bus0.OP = op;
      if (push) exp0_q.push_back(exp);
    end
    @(posedge clk); #1;
    // operands change after accept; the engine must ignore this
    if (which) begin
      bus1.in_valid = 1'b0; bus1.D = $urandom; bus1.S = 5'($urandom); bus1.OP = 3'($urandom);
    end else begin
      bus0.in_valid = 1'b0; bus0.D = $urandom; bus0.S = 5'($urandom); bus0.OP = 3'($urandom);
    end
  endtask

  task automatic wait_valid(input bit which, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!(which ? bus1.out_valid : bus0.out_valid) && lat < 64);
  endtask

  // directed request on a DUT with inline latency check
  task automatic op_lat(input string name, input bit which, input logic [31:0] d, input logic [4:0] s,
                        input logic [2:0] op, input logic [31:0] y, input logic err, input int exp_lat);
    int lat;
    drive_req(which, d, s, op, pack_exp(y, err), 1'b1);
    wait_valid(which, lat);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b0;
    bus0.in_valid = 1'b1; bus1.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus0.Y, bus0.out_valid, bus0.ERR, bus0.ZERO, bus0.in_ready} !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_dut0: got y=%h ov=%b err=%b zero=%b ir=%b, required 0/0/0/0/1",
               bus0.Y, bus0.out_valid, bus0.ERR, bus0.ZERO, bus0.in_ready);
    end
    checks++;
    if ({bus1.Y, bus1.out_valid, bus1.ERR, bus1.in_ready, st1} !== {32'd0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_dut1: got y=%h ov=%b err=%b ir=%b st=%0d, required 0/0/0/1/0",
               bus1.Y, bus1.out_valid, bus1.ERR, bus1.in_ready, st1);
    end
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    rst = 1'b1;
    op_lat("first_accept", 1'b0, 32'h00000001, 5'd1, SHOP_SRL, 32'h0, 1'b0, 5);
    // abort an operation in flight
    drive_req(1'b0, 32'hA5A5A5A5, 5'd3, SHOP_SLL, 34'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if ({bus0.in_ready, bus0.out_valid, bus0.Y} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_midop: got ir=%b ov=%b y=%h, required 1/0/0", bus0.in_ready, bus0.out_valid, bus0.Y);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus0.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_abort_no_output: got %0d valid cycles, required 0", seen);
    end
  endtask

  task automatic test_srl_sll();
    op_lat("srl_to_zero", 1'b0, 32'h00000001, 5'd1,    SHOP_SRL, 32'h00000000, 1'b0, 5);
    op_lat("srl_ones",    1'b0, 32'hFFFFFFFF, 5'd5,    SHOP_SRL, 32'h07FFFFFF, 1'b0, 5);
    op_lat("sll_17",      1'b0, 32'h101F568A, 5'h11,   SHOP_SLL, 32'hAD140000, 1'b0, 5);
  endtask

  task automatic test_sra();
    op_lat("sra_neg",  1'b0, 32'h9078AF1B, 5'h14, SHOP_SRA, 32'hFFFFF907, 1'b0, 5);
    op_lat("srl_cmp",  1'b0, 32'h9078AF1B, 5'h14, SHOP_SRL, 32'h00000907, 1'b0, 5);
    op_lat("sra_ones", 1'b0, 32'hFFFFFFFF, 5'h0F, SHOP_SRA, 32'hFFFFFFFF, 1'b0, 5);
  endtask

  task automatic test_rotate();
    op_lat("ror_31",   1'b0, 32'h198AF7B1, 5'h1F, SHOP_ROR, 32'h3315EF62, 1'b0, 5);
    op_lat("rol_4",    1'b0, 32'h7811BF90, 5'd4,  SHOP_ROL, 32'h811BF907, 1'b0, 5);
    op_lat("reserved", 1'b0, 32'h12345678, 5'd9,  3'b111,   32'h12345678, 1'b1, 5);
  endtask

  task automatic test_early_done();
    op_lat("early_s0",  1'b1, 32'hFFFFFFFF, 5'h00, SHOP_SRL, 32'hFFFFFFFF, 1'b0, 1);
    op_lat("early_s4",  1'b1, 32'h7811BF90, 5'h04, SHOP_SRL, 32'h07811BF9, 1'b0, 3);
    op_lat("early_s16", 1'b1, 32'h80000000, 5'h10, SHOP_SRL, 32'h00008000, 1'b0, 5);
    op_lat("early_res", 1'b1, 32'hCAFEF00D, 5'h02, 3'b101,   32'hCAFEF00D, 1'b1, 2);
  endtask

  task automatic test_backpressure();
    bus0.out_ready = 1'b0;
    op_lat("bp_req", 1'b0, 32'hF0F0F0F0, 5'd8, SHOP_ROR, 32'hF0F0F0F0, 1'b0, 5);
    for (int i = 0; i < 10; i++) begin
      bus0.in_valid = 1'($urandom_range(0, 1));
      bus0.D = $urandom;
      @(posedge clk); #1;
      checks++;
      if ({bus0.out_valid, bus0.in_ready, bus0.Y, st0} !== {1'b1, 1'b0, 32'hF0F0F0F0, 2'd2}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got ov=%b ir=%b y=%h st=%0d, required 1/0/f0f0f0f0/2",
                 i, bus0.out_valid, bus0.in_ready, bus0.Y, st0);
      end
    end
    bus0.in_valid = 1'b1;
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus0.in_ready, bus0.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: got ir=%b ov=%b, required 1/0 with no accept", bus0.in_ready, bus0.out_valid);
    end
    bus0.in_valid = 1'b0;
    op_lat("bp_next", 1'b0, 32'h00000080, 5'd7, SHOP_SRL, 32'h00000001, 1'b0, 5);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [4:0]  s;
    logic [2:0]  op;
    int          el;
    for (int i = 0; i < 24; i++) begin
      d  = $urandom;
      s  = 5'($urandom_range(0, 31));
      op = 3'($urandom_range(0, 7));
      op_lat("rand0", 1'b0, d, s, op, ref_y(d, s, op), (op > 3'd4), 5);
      el = 1;
      for (int b = 0; b < 5; b++) if (s[b]) el = b + 1;
      op_lat("rand1", 1'b1, d, s, op, ref_y(d, s, op), (op > 3'd4), el);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus0.in_valid = 1'b0; bus0.D = '0; bus0.S = '0; bus0.OP = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.D = '0; bus1.S = '0; bus1.OP = '0; bus1.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_srl_sll();
    test_sra();
    test_rotate();
    test_early_done();
    test_backpressure();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp0_q.size() + exp1_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d results outstanding, required 0", exp0_q.size() + exp1_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
